otsu_histogram: RTL and testbench
=================================

# otsu_histogram

Upstream stage of the Otsu thresholding pipeline. Accumulates an 8-bit grayscale frame into a 256-bin pixel histogram held in on-chip memory. Once the frame's last pixel is accepted, it streams every bin as an (i, n_i) pair, in ascending intensity order, to the per-bin probability stages (w0/w1/mean accumulators). It also reports the frame's total pixel count.

## Interface
Parameters:
- COUNT_WIDTH, 32, width of each bin counter and of the total counter; matches the n_i width of downstream stages.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- reset  in  1  asynchronous, active-low; 0 resets the block immediately, release is synchronous to clk.
- start  in  1  one-cycle request to begin a frame; ignored while busy=1.
- pix_valid  in  1  pixel present on pix_data.
- pix_data  in  8  pixel intensity.
- pix_last  in  1  qualifies the final pixel of the frame.
- pix_ready  out  1  block accepts a pixel this cycle (ACCUM only).
- out_valid  out  1  out_i/out_n_i valid.
- out_ready  in  1  downstream accepts the current pair.
- out_i  out  8  bin index.
- out_n_i  out  COUNT_WIDTH  bin count.
- out_last  out  1  high with out_i=255.
- total  out  COUNT_WIDTH  accepted pixels this frame; stable from DRAIN until next start.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the final bin handshake.

## Operation
- States: IDLE, CLEAR, ACCUM, FLUSH, DRAIN.
- IDLE: start=1 -> CLEAR; total <= 0; clear address <= 0.
- CLEAR: writes 0 to one bin per cycle, addresses 0..255. After address 255 -> ACCUM.
- ACCUM: pix_ready=1. A pixel is accepted on pix_valid & pix_ready. Accepted pixels enter a 2-stage read-modify-write pipeline:
  - stage 1 reads the bin;
  - stage 2 writes count+1.
- Same-bin hazards on back-to-back or one-apart pixels are resolved by forwarding the in-flight count. The block sustains one pixel per cycle with no stall.
- Accepting a pixel with pix_last=1 -> FLUSH. pix_ready drops the following cycle.
- FLUSH: 2 cycles to retire the pipeline, then -> DRAIN.
- DRAIN: the next bin is prefetched, giving one pair per cycle while out_ready=1. A handshake is out_valid & out_ready. Handshake at out_i=255 -> IDLE with done=1 for one cycle.
- While out_valid=1 and out_ready=0, out_i, out_n_i and out_last hold stable.
- Counter arithmetic: modulo 2^COUNT_WIDTH unless saturation is enabled (see Configuration). total follows the same rule.
- start during busy: ignored, no side effects.
- pix_valid outside ACCUM: ignored, never counted.

## Timing
- Reset values: pix_ready=0, out_valid=0, out_i=0, out_n_i=0, out_last=0, total=0, busy=0, done=0, state=IDLE. Memory contents are don't-care because every frame begins with CLEAR.
- start sampled in cycle 0 -> busy=1 in cycle 1; CLEAR occupies cycles 1..256; pix_ready=1 from cycle 257.
- pix_last accepted in cycle t -> FLUSH in t+1, t+2 -> first out_valid (out_i=0) in t+3.
- Full drain with out_ready held high: 256 cycles. done is asserted the cycle after the out_i=255 handshake, together with busy=0.
- Reset asserted mid-operation: aborts immediately to reset values. No partial pairs or done pulse are emitted.

## Configuration
- HIST_SATURATE_EN defined:
  - bin counters and total clamp at 2^COUNT_WIDTH-1;
  - further increments leave them unchanged.
- HIST_SATURATE_EN undefined:
  - counters wrap modulo 2^COUNT_WIDTH.

## Test plan
- Reset release, no stimulus -> all outputs at reset values; pix_ready=0 for 256 cycles after start, 1 in cycle 257.
- Pixels 5,5,5,200 back-to-back, pix_last on 200, out_ready=1 -> n_i(5)=3, n_i(200)=1, all other bins 0; total=4; out_last only at out_i=255; done pulse 259 cycles after the pix_last accept (3 cycles to first out_valid plus 256 drain cycles).
- Same frame with out_ready toggling 1,0,0,1 -> no duplicated or skipped indices; data held stable during stalls; 256 handshakes total.
- Second frame after the first, single pixel 0 with pix_last -> n_i(0)=1, all other bins 0, total=1 (the previous frame's counts are cleared).
- COUNT_WIDTH=4, 20 pixels of value 7 -> n_i(7)=15 and total=15 with HIST_SATURATE_EN; n_i(7)=4 and total=4 without it.
- Reset asserted mid-ACCUM, then start with one pixel 9 -> n_i(9)=1 only; no done pulse from the aborted frame.

Source files
------------

// File: rtl/otsu_histogram.sv
// 256-bin histogram of an 8-bit frame, streamed out as ascending (i, n_i) pairs.
// Define HIST_SATURATE_EN to clamp bin counters and total at all-ones instead of wrapping.
module otsu_histogram #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   pix_valid,
  input  logic [7:0]             pix_data,
  input  logic                   pix_last,
  output logic                   pix_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_i,
  output logic [COUNT_WIDTH-1:0] out_n_i,
  output logic                   out_last,
  output logic [COUNT_WIDTH-1:0] total,
  output logic                   busy,
  output logic                   done
);
  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, FLUSH, DRAIN} state_t;
  state_t state, state_next;

  logic [COUNT_WIDTH-1:0] mem [0:255];
  logic [COUNT_WIDTH-1:0] rd_data;
  logic                   rd_en;
  logic [7:0]             rd_addr;
  logic                   wr_en;
  logic [7:0]             wr_addr;
  logic [COUNT_WIDTH-1:0] wr_data;

  logic [7:0]             clr_addr;
  logic                   flush_cnt;
  logic                   s1_valid;
  logic [7:0]             s1_addr;
  logic                   s2_valid;
  logic [7:0]             s2_addr;
  logic [COUNT_WIDTH-1:0] s2_count;
  logic                   accept;
  logic                   handshake;
  logic                   last_bin;
  logic [COUNT_WIDTH-1:0] base_count;
  logic [COUNT_WIDTH-1:0] inc_count;
  logic [COUNT_WIDTH-1:0] total_inc;

  function automatic logic [COUNT_WIDTH-1:0] bump(input logic [COUNT_WIDTH-1:0] v);
`ifdef HIST_SATURATE_EN
    return (&v) ? v : v + COUNT_WIDTH'(1);
`else
    return v + COUNT_WIDTH'(1);
`endif
  endfunction

  assign accept    = pix_valid & pix_ready;
  assign handshake = out_valid & out_ready;
  assign last_bin  = (out_i == 8'd255);

  // The read issued for a pixel misses the write of the pixel just ahead of it,
  // so a same-bin match against the retiring stage takes its fresh count.
  assign base_count = (s2_valid && (s2_addr == s1_addr)) ? s2_count : rd_data;
  assign inc_count  = bump(base_count);
  assign total_inc  = bump(total);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CLEAR;
      CLEAR:   if (clr_addr == 8'd255) state_next = ACCUM;
      ACCUM:   if (accept && pix_last) state_next = FLUSH;
      FLUSH:   if (flush_cnt) state_next = DRAIN;
      DRAIN:   if (handshake && last_bin) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pix_ready = (state == ACCUM);
    out_valid = (state == DRAIN);
    busy      = (state != IDLE);
    out_last  = out_valid && last_bin;
    out_n_i   = out_valid ? rd_data : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_addr  <= '0;
      flush_cnt <= 1'b0;
      total     <= '0;
      out_i     <= '0;
      done      <= 1'b0;
      s1_valid  <= 1'b0;
      s1_addr   <= '0;
      s2_valid  <= 1'b0;
      s2_addr   <= '0;
      s2_count  <= '0;
    end else begin
      done     <= handshake && last_bin;
      s1_valid <= accept;
      s1_addr  <= pix_data;
      s2_valid <= s1_valid;
      s2_addr  <= s1_addr;
      s2_count <= inc_count;
      if (handshake) out_i <= out_i + 8'd1;
      case (state)
        IDLE: if (start) begin
          total    <= '0;
          clr_addr <= '0;
        end
        CLEAR: clr_addr <= clr_addr + 8'd1;
        ACCUM: begin
          flush_cnt <= 1'b0;
          if (accept) total <= total_inc;
        end
        FLUSH:   flush_cnt <= ~flush_cnt;
        default: ;
      endcase
    end
  end

  // Second flush cycle prefetches bin 0; each drain handshake prefetches the next bin.
  assign rd_en   = accept || ((state == FLUSH) && flush_cnt) || (handshake && !last_bin);
  assign rd_addr = (state == ACCUM) ? pix_data : ((state == FLUSH) ? 8'd0 : out_i + 8'd1);
  assign wr_en   = (state == CLEAR) || s1_valid;
  assign wr_addr = (state == CLEAR) ? clr_addr : s1_addr;
  assign wr_data = (state == CLEAR) ? '0 : inc_count;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: tb/tb_otsu_histogram.sv
// Self-checking bench for otsu_histogram: random frames against an array histogram model.
module tb_otsu_histogram;
  localparam int CW = 32;
  localparam int SW = 4;
`ifdef HIST_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          start, pix_valid, pix_last, out_ready;
  logic [7:0]    pix_data;
  logic          pix_ready, out_valid, out_last, busy, done;
  logic [7:0]    out_i;
  logic [CW-1:0] out_n_i, total;

  logic          s_start, s_pix_valid, s_pix_last, s_out_ready;
  logic [7:0]    s_pix_data;
  logic          s_pix_ready, s_out_valid, s_out_last, s_busy, s_done;
  logic [7:0]    s_out_i;
  logic [SW-1:0] s_out_n_i, s_total;

  otsu_histogram #(.COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_last(pix_last), .pix_ready(pix_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_i(out_i), .out_n_i(out_n_i), .out_last(out_last), .total(total), .busy(busy), .done(done)
  );

  otsu_histogram #(.COUNT_WIDTH(SW)) dut_small (
    .clk(clk), .reset(reset), .start(s_start), .pix_valid(s_pix_valid), .pix_data(s_pix_data),
    .pix_last(s_pix_last), .pix_ready(s_pix_ready), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_i(s_out_i), .out_n_i(s_out_n_i), .out_last(s_out_last), .total(s_total), .busy(s_busy),
    .done(s_done)
  );

  int total_cnt = 0;
  int bad = 0;
  int cyc = 0;
  int t_last = 0;
  int unsigned hist [256];
  int unsigned tot;
  logic [7:0] pq [$];

  always @(posedge clk) cyc++;

  task automatic start_frame();
    bit seen = 1'b0;
    for (int b = 0; b < 256; b++) hist[b] = 0;
    tot = 0;
    start = 1'b1;
    pix_valid = 1'($urandom_range(0, 1));
    pix_data = 8'($urandom);
    for (int i = 1; i <= 256; i++) begin
      @(negedge clk);
      if (i == 1) begin
        total_cnt++;
        if (busy !== 1'b1) begin bad++; $display("FAIL busy_cycle1 got=%b want=1", busy); end
      end
      if (pix_ready !== 1'b0) seen = 1'b1;
      start = (i < 256) ? 1'($urandom_range(0, 1)) : 1'b0;
      pix_valid = (i < 256) ? 1'($urandom_range(0, 1)) : 1'b0;
      pix_data = 8'($urandom);
      pix_last = 1'($urandom_range(0, 1));
    end
    total_cnt++;
    if (seen) begin bad++; $display("FAIL clear_ready got=1 during clear want=0"); end
    @(negedge clk);
    total_cnt++;
    if (pix_ready !== 1'b1) begin bad++; $display("FAIL ready_cycle257 got=%b want=1", pix_ready); end
    pix_last = 1'b0;
  endtask

  task automatic send_frame(input bit gaps);
    for (int k = 0; k < pq.size(); k++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          pix_valid = 1'b0;
          @(negedge clk);
        end
      end
      total_cnt++;
      if (pix_ready !== 1'b1) begin bad++; $display("FAIL accum_ready k=%0d got=%b want=1", k, pix_ready); end
      pix_valid = 1'b1;
      pix_data = pq[k];
      pix_last = (k == pq.size() - 1);
      hist[pq[k]]++;
      tot++;
      t_last = cyc;
      @(negedge clk);
    end
    pix_last = 1'($urandom_range(0, 1));
    pix_valid = 1'($urandom_range(0, 1));
    pix_data = 8'($urandom);
    total_cnt++;
    if (pix_ready !== 1'b0) begin bad++; $display("FAIL ready_drop got=%b want=0", pix_ready); end
  endtask

  // mode 0: ready held high, 1: ready 1,0,0,1 repeating, 2: random ready
  task automatic collect_drain(input int mode);
    logic [3:0] pat = 4'b1001;
    int idx = 0, k = 0, first = -1, guard = 0;
    bit pend = 1'b0, early = 1'b0;
    logic [7:0] pi = '0;
    logic [CW-1:0] pn = '0;
    while (idx < 256 && guard < 3000) begin
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? pat[k % 4] : 1'($urandom_range(0, 1));
      k++;
      pix_valid = 1'($urandom_range(0, 1));
      pix_data = 8'($urandom);
      if (done === 1'b1) early = 1'b1;
      if (out_valid === 1'b1 && first < 0) begin
        first = cyc;
        total_cnt++;
        if (first != t_last + 3) begin bad++; $display("FAIL first_valid_cycle got=%0d want=%0d", first, t_last + 3); end
        total_cnt++;
        if (total !== CW'(tot)) begin bad++; $display("FAIL total got=%0d want=%0d", total, tot); end
      end
      if (pend) begin
        total_cnt++;
        if (out_valid !== 1'b1 || out_i !== pi || out_n_i !== pn) begin
          bad++; $display("FAIL stall_hold i got=%0d want=%0d n got=%0d want=%0d", out_i, pi, out_n_i, pn);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        total_cnt++;
        if (out_i !== 8'(idx) || out_n_i !== CW'(hist[idx]) || out_last !== (idx == 255)) begin
          bad++;
          $display("FAIL bin got i=%0d n=%0d last=%b want i=%0d n=%0d last=%b",
                   out_i, out_n_i, out_last, idx, hist[idx], (idx == 255));
        end
        idx++;
      end
      pend = (out_valid === 1'b1) && (out_ready === 1'b0);
      pi = out_i;
      pn = out_n_i;
      @(negedge clk);
      guard++;
    end
    out_ready = 1'b1;
    total_cnt++;
    if (idx != 256) begin bad++; $display("FAIL drain_count got=%0d want=256", idx); end
    total_cnt++;
    if (early) begin bad++; $display("FAIL done_early got=1 want=0"); end
    total_cnt++;
    if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL done_pulse got done=%b busy=%b want 1 0", done, busy); end
    if (mode == 0) begin
      total_cnt++;
      if (cyc != t_last + 259) begin bad++; $display("FAIL done_cycle got=%0d want=%0d", cyc, t_last + 259); end
    end
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL done_width got done=%b valid=%b want 0 0", done, out_valid); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 0; pix_valid = 0; pix_data = 0; pix_last = 0; out_ready = 1;
    s_start = 0; s_pix_valid = 0; s_pix_data = 0; s_pix_last = 0; s_out_ready = 1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({pix_ready, out_valid, out_i, out_n_i, out_last, total, busy, done} !== '0) begin
      bad++; $display("FAIL reset_vals got ready=%b valid=%b i=%0d n=%0d busy=%b done=%b want all 0",
                      pix_ready, out_valid, out_i, out_n_i, busy, done);
    end
    reset = 1'b1;
    repeat (5) @(negedge clk);
    total_cnt++;
    if ({pix_ready, out_valid, out_last, total, busy, done, s_busy, s_pix_ready} !== '0) begin
      bad++; $display("FAIL idle_vals got ready=%b valid=%b busy=%b done=%b want all 0", pix_ready, out_valid, busy, done);
    end
  endtask

  task automatic test_back_to_back();
    start_frame();
    pq = '{8'd5, 8'd5, 8'd5, 8'd200};
    send_frame(1'b0);
    collect_drain(0);
  endtask

  task automatic test_stall();
    start_frame();
    pq = '{8'd5, 8'd5, 8'd5, 8'd200};
    send_frame(1'b0);
    collect_drain(1);
  endtask

  task automatic test_second_frame();
    start_frame();
    pq = '{8'd0};
    send_frame(1'b0);
    collect_drain(0);
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++) begin
      int n = $urandom_range(40, 120);
      pq.delete();
      repeat (n) pq.push_back(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 5)));
      start_frame();
      send_frame(f != 0);
      collect_drain(f);
    end
  endtask

  task automatic test_reset_abort();
    bit seen = 1'b0;
    start_frame();
    pix_valid = 1'b1; pix_data = 8'd9; pix_last = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    total_cnt++;
    if ({busy, pix_ready, out_valid, done, total} !== '0) begin
      bad++; $display("FAIL abort_vals got busy=%b ready=%b total=%0d want 0 0 0", busy, pix_ready, total);
    end
    pix_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (300) begin
      @(negedge clk);
      if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    total_cnt++;
    if (seen) begin bad++; $display("FAIL abort_quiet got activity after abort want none"); end
    start_frame();
    pq = '{8'd9};
    send_frame(1'b0);
    collect_drain(0);
  endtask

  task automatic test_saturate();
    int w = 0, hs = 0, nz = 0;
    int exp_n = SAT ? ((20 > 15) ? 15 : 20) : (20 % 16);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    while (s_pix_ready !== 1'b1 && w < 400) begin @(negedge clk); w++; end
    total_cnt++;
    if (s_pix_ready !== 1'b1) begin bad++; $display("FAIL sat_ready got=%b want=1", s_pix_ready); end
    for (int k = 0; k < 20; k++) begin
      s_pix_valid = 1'b1; s_pix_data = 8'd7; s_pix_last = (k == 19);
      @(negedge clk);
    end
    s_pix_valid = 1'b0; s_pix_last = 1'b0; s_out_ready = 1'b1;
    w = 0;
    while (hs < 256 && w < 600) begin
      if (s_out_valid === 1'b1) begin
        if (s_out_i == 8'd7) begin
          total_cnt++;
          if (s_out_n_i !== SW'(exp_n)) begin bad++; $display("FAIL sat_bin7 got=%0d want=%0d", s_out_n_i, exp_n); end
          total_cnt++;
          if (s_total !== SW'(exp_n)) begin bad++; $display("FAIL sat_total got=%0d want=%0d", s_total, exp_n); end
        end else if (s_out_n_i !== '0) nz++;
        hs++;
      end
      @(negedge clk);
      w++;
    end
    total_cnt++;
    if (hs != 256 || nz != 0) begin bad++; $display("FAIL sat_drain got pairs=%0d nonzero=%0d want 256 0", hs, nz); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_second_frame();
    test_random();
    test_reset_abort();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total_cnt, bad);
    $finish;
  end
endmodule
